// File: rtl/uart_hex_formatter_if.sv
// Sample-in / byte-out bus of uart_hex_formatter.
// master = sample producer and UART FIFO side, slave = the formatter itself.
interface uart_hex_formatter_if #(
   parameter int pDataWidth = 24
);
   logic [pDataWidth-1:0] sample;
   logic                  sample_valid;
   logic                  sample_ready;
   logic [7:0]            tx_byte;
   logic                  tx_write;
   logic                  tx_busy;
   logic                  frame_busy;
   logic                  frame_done;

   modport master (
      output sample, sample_valid, tx_busy,
      input  sample_ready, tx_byte, tx_write, frame_busy, frame_done
   );

   modport slave (
      input  sample, sample_valid, tx_busy,
      output sample_ready, tx_byte, tx_write, frame_busy, frame_done
   );
endinterface

// File: rtl/uart_hex_formatter.sv
// Turns one binary sample into an ASCII hex text frame (MSB digit first, CR[LF]) for uart_fifo TX.
// Optional HEXFMT_SEQNUM_EN: prefix every frame with a 2-digit hex sequence number and ':'.
module uart_hex_formatter #(
   parameter int pDataWidth = 24,
   parameter bit pEolCrLf   = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_hex_formatter_if.slave  bus
);
   localparam int ND      = pDataWidth / 4;
   localparam int EOL_LEN = pEolCrLf ? 2 : 1;
`ifdef HEXFMT_SEQNUM_EN
   localparam int PRE_LEN = 3;
`else
   localparam int PRE_LEN = 0;
`endif
   localparam int NB = PRE_LEN + ND + EOL_LEN;
   localparam int CW = $clog2(NB + 1);

   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

   state_t                state_reg;
   logic [pDataWidth-1:0] sample_reg;
   logic [CW-1:0]         cnt_reg;
   logic [7:0]            tx_byte_reg;
   logic                  ready_reg;
   logic                  busy_reg;
   logic                  done_reg;
`ifdef HEXFMT_SEQNUM_EN
   logic [7:0]            seq_reg;
`endif

   logic                  accept;
   logic [CW-1:0]         idx_next;
   logic [pDataWidth-1:0] data_sel;
   logic [7:0]            char_next;
   logic [7:0]            digit_char [ND];

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // The first character is taken straight from the bus on accept; later ones from the latched copy.
   assign accept   = (state_reg == IDLE) && bus.sample_valid && ready_reg;
   assign idx_next = accept ? '0 : cnt_reg + CW'(1);
   assign data_sel = accept ? bus.sample : sample_reg;

   generate
      for (genvar gi = 0; gi < ND; gi++) begin : g_digit
         assign digit_char[gi] = hex_char(data_sel[(ND-1-gi)*4 +: 4]);
      end
   endgenerate

   always_comb begin
      char_next = 8'h0A;
      for (int j = 0; j < ND; j++) begin
         if (idx_next == CW'(PRE_LEN + j)) char_next = digit_char[j];
      end
      if (idx_next == CW'(PRE_LEN + ND)) char_next = 8'h0D;
`ifdef HEXFMT_SEQNUM_EN
      if (idx_next == CW'(0)) char_next = hex_char(seq_reg[7:4]);
      if (idx_next == CW'(1)) char_next = hex_char(seq_reg[3:0]);
      if (idx_next == CW'(2)) char_next = 8'h3A;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         sample_reg  <= '0;
         cnt_reg     <= '0;
         tx_byte_reg <= 8'h00;
         ready_reg   <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
`ifdef HEXFMT_SEQNUM_EN
         seq_reg     <= 8'h00;
`endif
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               ready_reg <= 1'b1;
               if (accept) begin
                  sample_reg  <= bus.sample;
                  tx_byte_reg <= char_next;
                  cnt_reg     <= '0;
                  ready_reg   <= 1'b0;
                  busy_reg    <= 1'b1;
                  state_reg   <= SEND;
               end
            end
            SEND: begin
               if (!bus.tx_busy) state_reg <= GAP;
            end
            // One idle cycle after each write so the FIFO's busy flag is current before the next one.
            GAP: begin
               if (cnt_reg == CW'(NB - 1)) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
`ifdef HEXFMT_SEQNUM_EN
                  seq_reg   <= seq_reg + 8'd1;
`endif
               end else begin
                  cnt_reg     <= idx_next;
                  tx_byte_reg <= char_next;
                  state_reg   <= SEND;
               end
            end
            DONE: begin
               state_reg <= IDLE;
               ready_reg <= 1'b1;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.sample_ready = ready_reg;
   assign bus.tx_byte      = tx_byte_reg;
   assign bus.tx_write     = (state_reg == SEND) && !bus.tx_busy;
   assign bus.frame_busy   = busy_reg;
   assign bus.frame_done   = done_reg;
endmodule

// File: tb/tb_uart_hex_formatter.sv
// Scoreboard bench for uart_hex_formatter: a 24-bit CRLF instance and an 8-bit CR-only instance.
// Expected frames are queued at accept time and popped on every observed write strobe.
module tb_uart_hex_formatter;
`ifdef HEXFMT_SEQNUM_EN
   localparam int PRE = 3;
`else
   localparam int PRE = 0;
`endif
   localparam int NB_A = PRE + 6 + 2;
   localparam int NB_B = PRE + 2 + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   uart_hex_formatter_if #(.pDataWidth(24)) bus_a ();
   uart_hex_formatter_if #(.pDataWidth(8))  bus_b ();

   uart_hex_formatter #(.pDataWidth(24), .pEolCrLf(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   uart_hex_formatter #(.pDataWidth(8),  .pEolCrLf(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] exp_a [$];
   logic [7:0] exp_b [$];
   int         wr_edges_a [$];
   int         wr_cnt_a = 0, wr_cnt_b = 0;
   int         extra_a = 0, extra_b = 0;
   int         busy_viol = 0;
   logic [7:0] seq_a = 8'h00;
   logic [7:0] seq_b = 8'h00;
   string      hx = "0123456789ABCDEF";

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Writes land on the next rising edge, so a strobe seen here is logged as edge cyc+1.
   always @(negedge clk) begin
      if (bus_a.tx_write) begin
         wr_cnt_a++;
         wr_edges_a.push_back(cyc + 1);
         if (bus_a.tx_busy) busy_viol++;
         if (exp_a.size() > 0) check("byte_a", bus_a.tx_byte, exp_a.pop_front());
         else extra_a++;
      end
      if (bus_b.tx_write) begin
         wr_cnt_b++;
         if (exp_b.size() > 0) check("byte_b", bus_b.tx_byte, exp_b.pop_front());
         else extra_b++;
      end
   end

   task automatic push_a(input logic [23:0] s, input int keep);
      logic [7:0] f [$];
      logic [3:0] n;
`ifdef HEXFMT_SEQNUM_EN
      f.push_back(hx[seq_a[7:4]]);
      f.push_back(hx[seq_a[3:0]]);
      f.push_back(8'h3A);
`endif
      for (int k = 5; k >= 0; k--) begin
         n = s[k*4 +: 4];
         f.push_back(hx[n]);
      end
      f.push_back(8'h0D);
      f.push_back(8'h0A);
      for (int k = 0; k < keep && k < f.size(); k++) exp_a.push_back(f[k]);
   endtask

   task automatic send_a(input logic [23:0] s, input int keep, output int acc);
      for (int t = 0; t < 100 && !bus_a.sample_ready; t++) @(negedge clk);
      check("ready_wait_a", bus_a.sample_ready, 1);
      push_a(s, keep);
      bus_a.sample       = s;
      bus_a.sample_valid = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      bus_a.sample_valid = 1'b0;
      bus_a.sample       = ~s;
      check("accept_busy_a", bus_a.frame_busy, 1);
      check("accept_ready_a", bus_a.sample_ready, 0);
      $display("tx frame A: sample=0x%06h accepted at cycle %0d", s, acc);
   endtask

   task automatic wait_a(input string tag, input int acc, input int extra);
      int de = -1000, re = -1000;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         if (bus_a.frame_done) begin de = cyc; break; end
      end
      check({tag, "_done_cyc"}, de - acc, 2*NB_A + extra);
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (bus_a.sample_ready) begin re = cyc; break; end
      end
      check({tag, "_ready_cyc"}, re - acc, 2*NB_A + 1 + extra);
      check({tag, "_done_pulse"}, bus_a.frame_done, 0);
      check({tag, "_busy_end"}, bus_a.frame_busy, 0);
      seq_a = seq_a + 8'd1;
   endtask

   initial begin
      int acc, w0;
      logic [23:0] r;
      logic [7:0]  b3;
      bus_a.sample = '0; bus_a.sample_valid = 1'b0; bus_a.tx_busy = 1'b0;
      bus_b.sample = '0; bus_b.sample_valid = 1'b0; bus_b.tx_busy = 1'b0;

      // Reset state and release
      repeat (3) @(negedge clk);
      check("rst_ready", bus_a.sample_ready, 0);
      check("rst_byte", bus_a.tx_byte, 8'h00);
      check("rst_write", bus_a.tx_write, 0);
      check("rst_busy", bus_a.frame_busy, 0);
      check("rst_done", bus_a.frame_done, 0);
      rst = 1'b0;
      @(negedge clk);
      check("rel_ready_a", bus_a.sample_ready, 1);
      check("rel_ready_b", bus_b.sample_ready, 1);
      w0 = wr_cnt_a + wr_cnt_b;
      repeat (100) @(negedge clk);
      check("idle_writes", wr_cnt_a + wr_cnt_b - w0, 0);
      $display("idle: 100 cycles, writes=%0d", wr_cnt_a + wr_cnt_b - w0);

      // Nominal frame with exact write timing
      wr_edges_a.delete();
      send_a(24'h12AB3F, NB_A, acc);
      wait_a("t2", acc, 0);
      check("t2_nwr", wr_edges_a.size(), NB_A);
      for (int k = 0; k < NB_A && k < wr_edges_a.size(); k++)
         check("t2_wr_edge", wr_edges_a[k] - acc, 1 + 2*k);

      // Stall for 5 cycles on the third byte
      wr_edges_a.delete();
      w0 = wr_cnt_a;
`ifdef HEXFMT_SEQNUM_EN
      b3 = 8'h3A;
`else
      b3 = 8'h30;
`endif
      send_a(24'h000000, NB_A, acc);
      repeat (4) @(posedge clk);
      #1;
      bus_a.tx_busy = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("t3_no_strobe", bus_a.tx_write, 0);
         check("t3_hold", bus_a.tx_byte, b3);
      end
      @(posedge clk);
      #1;
      bus_a.tx_busy = 1'b0;
      wait_a("t3", acc, 5);
      check("t3_nwr", wr_cnt_a - w0, NB_A);
      if (wr_edges_a.size() > 2) check("t3_wr2_edge", wr_edges_a[2] - acc, 10);

      // Reset in the middle of a frame
      w0 = wr_cnt_a;
      send_a(24'hFFFFFF, 3, acc);
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("t4_write_abort", bus_a.tx_write, 0);
      check("t4_busy_abort", bus_a.frame_busy, 0);
      check("t4_byte_abort", bus_a.tx_byte, 8'h00);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      seq_a = 8'h00;
      seq_b = 8'h00;
      repeat (4) @(negedge clk);
      check("t4_nwr_partial", wr_cnt_a - w0, 3);
      w0 = wr_cnt_a;
      send_a(24'h000001, NB_A, acc);
      wait_a("t4", acc, 0);
      check("t4_nwr_full", wr_cnt_a - w0, NB_A);

      // A few random samples
      for (int i = 0; i < 4; i++) begin
         r = 24'($urandom);
         send_a(r, NB_A, acc);
         wait_a("rnd", acc, 0);
      end

      // Narrow CR-only instance
      begin
         int de = -1000, re = -1000;
`ifdef HEXFMT_SEQNUM_EN
         exp_b.push_back(hx[seq_b[7:4]]);
         exp_b.push_back(hx[seq_b[3:0]]);
         exp_b.push_back(8'h3A);
`endif
         exp_b.push_back(8'h39);
         exp_b.push_back(8'h43);
         exp_b.push_back(8'h0D);
         w0 = wr_cnt_b;
         check("t5_ready", bus_b.sample_ready, 1);
         bus_b.sample       = 8'h9C;
         bus_b.sample_valid = 1'b1;
         @(posedge clk);
         #1;
         acc = cyc;
         bus_b.sample_valid = 1'b0;
         bus_b.sample       = 8'h00;
         $display("tx frame B: sample=0x9c accepted at cycle %0d", acc);
         for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus_b.frame_done) begin de = cyc; break; end
         end
         check("t5_done_cyc", de - acc, 2*NB_B);
         for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (bus_b.sample_ready) begin re = cyc; break; end
         end
         check("t5_ready_cyc", re - acc, 2*NB_B + 1);
         check("t5_nwr", wr_cnt_b - w0, NB_B);
         seq_b = seq_b + 8'd1;
      end

`ifdef HEXFMT_SEQNUM_EN
      // Sequence number wrap over 257 frames from reset
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seq_a = 8'h00;
      for (int i = 0; i < 257; i++) begin
         send_a(24'($urandom), NB_A, acc);
         wait_a("seq", acc, 0);
      end
`endif

      check("sb_left_a", exp_a.size(), 0);
      check("sb_left_b", exp_b.size(), 0);
      check("extra_wr_a", extra_a, 0);
      check("extra_wr_b", extra_b, 0);
      check("write_while_busy", busy_viol, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
